// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side drain controller: FIFO pop issue, capture and 2-entry valid/ready output buffer
//
// Purpose: pops the FIFO whenever it is non-empty and downstream room exists,
// captures data_out with the FIFO's read latency and re-presents the words in
// order on a valid/ready stream.
//
// Build option: define FIFO_RD_FWFT_EN for a first-word-fall-through FIFO
// (capture on pop). Undefined: registered-read FIFO, capture one cycle after pop.
//
// Ports:
//   rdclk     in   read-domain clock, rising edge
//   rd_rst    in   synchronous active-high reset
//   empty     in   FIFO empty flag
//   data_out  in   FIFO read data [WIDTH]
//   pop       out  FIFO read strobe
//   m_data    out  stream data, head of the output buffer [WIDTH]
//   m_valid   out  stream valid
//   m_ready   in   stream ready

module fifo_rd_drain #(
    parameter int WIDTH = 8
) (
    input  logic             rdclk,
    input  logic             rd_rst,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             pop,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       cnt;
    logic [1:0]       occ;
    logic             take;
    logic             cap;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;

    assign cnt     = state;
    assign m_valid = (state != EMPTY);
    assign m_data  = head_q;
    assign take    = m_valid && m_ready;

`ifdef FIFO_RD_FWFT_EN
    // data_out is already valid alongside !empty, so the pop itself is the capture.
    assign occ = cnt;
    assign cap = pop;
`else
    // Registered-read FIFO: the word popped this cycle shows up next cycle.
    logic inflight;

    assign occ = cnt + {1'b0, inflight};
    assign cap = inflight;

    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop;
        end
    end
`endif

    // occ - take < 2, rearranged to avoid unsigned underflow when occ == 0.
    assign pop = !empty && !rd_rst && (occ < (2'd2 + {1'b0, take}));

    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (cap) begin
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (cap && !take) begin
                    state_nxt = TWO;
                end else if (take && !cap) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (take && !cap) begin
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Buffer storage: head_q feeds m_data, tail_q holds the second word.
    // data_out is only sampled on capture cycles, so X there never lands.
    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (cap && take) begin
            if (state == ONE) begin
                head_q <= data_out;
            end else if (state == TWO) begin
                head_q <= tail_q;
                tail_q <= data_out;
            end
        end else if (cap) begin
            if (state == EMPTY) begin
                head_q <= data_out;
            end else if (state == ONE) begin
                tail_q <= data_out;
            end
        end else if (take) begin
            if (state == TWO) begin
                head_q <= tail_q;
            end
        end
    end

    // The pop gating keeps occupancy at 2, so a capture into a full buffer is a bug.
    a_no_overflow: assert property (@(posedge rdclk) disable iff (rd_rst)
        !((state == TWO) && cap && !take));

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - self-checking bench for fifo_rd_drain
module tb_fifo_rd_drain;

    logic       rdclk = 1'b0;
    logic       rd_rst;
    logic       empty;
    logic [7:0] data_out;
    logic       pop;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    fifo_rd_drain #(.WIDTH(8)) dut (
        .rdclk    (rdclk),
        .rd_rst   (rd_rst),
        .empty    (empty),
        .data_out (data_out),
        .pop      (pop),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    always #5 rdclk = ~rdclk;

`ifdef FIFO_RD_FWFT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int received = 0;
    int pop_empty_err = 0;
    bit model_on = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         exp_av[$];

    typedef struct {
        bit         rst;
        bit         ready;
        int         push;
        bit         exp_pop;
        bit         exp_valid;
        bit         chk_data;
        logic [7:0] exp_data;
    } vec_t;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic refresh();
        empty = (fifo_q.size() == 0);
`ifdef FIFO_RD_FWFT_EN
        data_out = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
`endif
    endtask

    // One clock cycle: sample before the edge, compare with the reference
    // model, then advance the FIFO model and the reference model.
    task automatic tick(output bit p, output bit v, output logic [7:0] d);
        bit ve;
        bit tk;
        bit pe;
        logic [7:0] w;
        refresh();
        #1;
        p = pop;
        v = m_valid;
        d = m_data;
        ve = (exp_q.size() > 0) && (exp_av[0] <= cyc);
        tk = ve && m_ready;
        pe = !empty && !rd_rst && ((exp_q.size() - int'(tk)) < 2);
        if (model_on) begin
            check("pop_model", p, pe);
            check("valid_model", v, ve);
            if (ve) check("data_model", d, exp_q[0]);
        end
        if (p && empty) pop_empty_err++;
        @(posedge rdclk);
        #1;
        if (rd_rst) begin
            exp_q.delete();
            exp_av.delete();
            model_on = 1;
            data_out = 8'($urandom);
        end else begin
            if (tk) begin
                void'(exp_q.pop_front());
                void'(exp_av.pop_front());
                received++;
            end
            if (p && fifo_q.size() != 0) begin
                w = fifo_q.pop_front();
                exp_q.push_back(w);
                exp_av.push_back(cyc + LAT);
`ifndef FIFO_RD_FWFT_EN
                data_out = w;
`endif
            end else begin
                data_out = 8'($urandom);
            end
        end
        cyc++;
    endtask

    function automatic vec_t mk(bit rst, bit ready, int push, bit ep, bit ev, bit cd, logic [7:0] ed);
        vec_t t;
        t.rst = rst; t.ready = ready; t.push = push; t.exp_pop = ep;
        t.exp_valid = ev; t.chk_data = cd; t.exp_data = ed;
        return t;
    endfunction

    initial begin
        vec_t vecs[12];
        bit p, v;
        logic [7:0] d;
        int npop, ntake, fpop, lpop, ftake, ltake, rstart;
        bit stable, seen;
        logic [7:0] first_d;
        logic [7:0] got[$];
        logic [7:0] next_w;

        rd_rst = 1'b1;
        m_ready = 1'b1;
        data_out = 8'h00;
        empty = 1'b1;
        tick(p, v, d);
        tick(p, v, d);

        // Reset pulse with a non-empty FIFO, then the single-word sequence.
        vecs[0] = mk(1, 1, 8'h11, 0, 0, 1, 8'h00);
        vecs[1] = mk(1, 1, -1,    0, 0, 1, 8'h00);
        vecs[2] = mk(1, 1, -1,    0, 0, 1, 8'h00);
        vecs[3] = mk(0, 1, -1,    1, 0, 1, 8'h00);
`ifdef FIFO_RD_FWFT_EN
        vecs[4] = mk(0, 1, -1,    0, 1, 1, 8'h11);
        vecs[5] = mk(0, 1, -1,    0, 0, 0, 8'h00);
        vecs[6] = mk(0, 1, -1,    0, 0, 0, 8'h00);
        vecs[7] = mk(0, 1, 8'hA5, 1, 0, 0, 8'h00);
        vecs[8] = mk(0, 1, -1,    0, 1, 1, 8'hA5);
        vecs[9] = mk(0, 1, -1,    0, 0, 0, 8'h00);
`else
        vecs[4] = mk(0, 1, -1,    0, 0, 0, 8'h00);
        vecs[5] = mk(0, 1, -1,    0, 1, 1, 8'h11);
        vecs[6] = mk(0, 1, -1,    0, 0, 0, 8'h00);
        vecs[7] = mk(0, 1, 8'hA5, 1, 0, 0, 8'h00);
        vecs[8] = mk(0, 1, -1,    0, 0, 0, 8'h00);
        vecs[9] = mk(0, 1, -1,    0, 1, 1, 8'hA5);
`endif
        vecs[10] = mk(0, 1, -1,   0, 0, 0, 8'h00);
        vecs[11] = mk(0, 1, -1,   0, 0, 0, 8'h00);

        for (int i = 0; i < 12; i++) begin
            rd_rst = vecs[i].rst;
            m_ready = vecs[i].ready;
            if (vecs[i].push >= 0) fifo_q.push_back(8'(vecs[i].push));
            tick(p, v, d);
            check($sformatf("vec%0d_pop", i), p, vecs[i].exp_pop);
            check($sformatf("vec%0d_valid", i), v, vecs[i].exp_valid);
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        end

        // Streaming: 16 words, m_ready held high.
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        npop = 0; ntake = 0; fpop = -1; lpop = -1; ftake = -1; ltake = -1;
        m_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick(p, v, d);
            if (p) begin npop++; if (fpop < 0) fpop = i; lpop = i; end
            if (v) begin
                ntake++; if (ftake < 0) ftake = i; ltake = i;
                got.push_back(d);
            end
        end
        check("stream_pops", npop, 16);
        check("stream_pop_span", lpop - fpop, 15);
        check("stream_takes", ntake, 16);
        check("stream_take_span", ltake - ftake, 15);
        for (int i = 0; i < 16 && i < got.size(); i++) check("stream_order", got[i], i);

        // Backpressure: 8 words queued, m_ready low for 10 cycles.
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h30 + 8'(i));
        m_ready = 1'b0;
        npop = 0; stable = 1; seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(p, v, d);
            if (p) npop++;
            if (v) begin
                if (!seen) begin seen = 1; first_d = d; end
                else if (d != first_d) stable = 0;
            end
        end
        check("bp_pops", npop, 2);
        check("bp_seen", seen, 1);
        check("bp_head", first_d, 8'h30);
        check("bp_stable", stable, 1);
        m_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 16; i++) begin
            tick(p, v, d);
            if (v) got.push_back(d);
        end
        check("bp_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("bp_order", got[i], 8'h30 + i);

        // Random ready and random refill; the reference model checks order.
        rstart = received;
        next_w = 8'h80;
        for (int i = 0; i < 4000 && (received - rstart) < 200; i++) begin
            if ($urandom_range(1, 0) == 1 && fifo_q.size() < 6) begin
                fifo_q.push_back(next_w);
                next_w = next_w + 8'd1;
            end
            m_ready = $urandom_range(1, 0);
            tick(p, v, d);
        end
        check("rand_count_reached", int'((received - rstart) >= 200), 1);
        m_ready = 1'b1;
        fifo_q.delete();
        for (int i = 0; i < 6; i++) tick(p, v, d);

        // Reset mid-stream with a buffered word and one in flight.
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'hC0 + 8'(i));
        m_ready = 1'b0;
        tick(p, v, d);
        tick(p, v, d);
        rd_rst = 1'b1;
        tick(p, v, d);
        rd_rst = 1'b0;
        tick(p, v, d);
        check("mid_rst_valid", v, 0);
        m_ready = 1'b1;
        seen = 0;
        got.delete();
        for (int i = 0; i < 12; i++) begin
            tick(p, v, d);
            if (v) got.push_back(d);
        end
        check("mid_rst_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("mid_rst_order", got[i], 8'hC2 + i);

        check("pop_while_empty", pop_empty_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
